// File: rtl/led_pkg.sv
// Shared types and sizes for the LED pattern sequencer.
// The FSM state encoding and the table geometry live here.
package led_pkg;

  localparam int LED_W   = 4;
  localparam int STEP_W  = 3;
  localparam int N_STEPS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler that emits a one-cycle tick every TICK_DIV enabled cycles.
// The tick fires combinationally at the terminal count; a clear or a low enable holds the count at 0.
module led_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: plays an 8-entry (led, duration) table once or looping on a prescaled tick.
// led/busy follow start or stop one edge later; every entry shows for max(dur,1)*TICK_DIV cycles, no gaps.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV = 50_000,
  parameter int DUR_W    = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [LED_W-1:0]  cfg_led,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [STEP_W-1:0] last_step,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step
);

  logic [LED_W-1:0]  tbl_led [N_STEPS];
  logic [DUR_W-1:0]  tbl_dur [N_STEPS];

  state_t            state, state_nxt;
  logic [DUR_W-1:0]  dur_cnt, dur_nxt;
  logic [LED_W-1:0]  led_nxt;
  logic [STEP_W-1:0] step_nxt, last_q, last_nxt;
  logic              loop_q, loop_nxt, done_nxt;
  logic              start_acc, tick;

  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      (state == ST_RUN),
    .clr     (start_acc),
    .tick    (tick)
  );

  // Nonblocking table update gives loads in the same cycle the old contents.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STEPS; i++) begin
        tbl_led[i] <= '0;
        tbl_dur[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_led[cfg_addr] <= cfg_led;
      tbl_dur[cfg_addr] <= cfg_dur;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      led     <= '0;
      step    <= '0;
      dur_cnt <= '0;
      done    <= 1'b0;
      last_q  <= '0;
      loop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      led     <= led_nxt;
      step    <= step_nxt;
      dur_cnt <= dur_nxt;
      done    <= done_nxt;
      last_q  <= last_nxt;
      loop_q  <= loop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    step_nxt  = step;
    dur_nxt   = dur_cnt;
    done_nxt  = 1'b0;
    last_nxt  = last_q;
    loop_nxt  = loop_q;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        led_nxt  = '0;
        step_nxt = '0;
        if (start && !stop) begin
          start_acc = 1'b1;
          last_nxt  = last_step;
          loop_nxt  = loop;
          led_nxt   = tbl_led[0];
          dur_nxt   = eff_dur(tbl_dur[0]);
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          led_nxt   = '0;
          step_nxt  = '0;
        end else if (tick) begin
          if (dur_cnt > DUR_W'(1)) begin
            dur_nxt = dur_cnt - DUR_W'(1);
          end else if (step < last_q) begin
            step_nxt = step + STEP_W'(1);
            led_nxt  = tbl_led[step_nxt];
            dur_nxt  = eff_dur(tbl_dur[step_nxt]);
          end else if (loop_q) begin
            step_nxt = '0;
            led_nxt  = tbl_led[0];
            dur_nxt  = eff_dur(tbl_dur[0]);
          end else begin
            state_nxt = ST_IDLE;
            led_nxt   = '0;
            step_nxt  = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with TICK_DIV=4: a cycle-countdown model is compared every cycle,
// plus literal expectations on directed scenarios.
module tb_led_seq_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 16;

  logic             sys_clk;
  logic             rst_n;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [3:0]       cfg_led;
  logic [DUR_W-1:0] cfg_dur;
  logic [2:0]       last_step;
  logic             loop;
  logic             start;
  logic             stop;
  logic [3:0]       led;
  logic             busy;
  logic             done;
  logic [2:0]       step;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done_seen = 0;
  bit cmp_en = 0;

  led_seq_ctrl #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_led   (cfg_led),
    .cfg_dur   (cfg_dur),
    .last_step (last_step),
    .loop      (loop),
    .start     (start),
    .stop      (stop),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .step      (step)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Model: each displayed entry owns a countdown of max(dur,1)*TICK_DIV cycles.
  logic [3:0] m_tbl_led [8];
  int         m_tbl_dur [8];
  bit         m_run, m_loop, m_done;
  int         m_idx, m_rem, m_last;
  logic [3:0] m_led;

  task automatic show(input int i);
    m_idx = i;
    m_led = m_tbl_led[i];
    m_rem = ((m_tbl_dur[i] == 0) ? 1 : m_tbl_dur[i]) * TICK_DIV;
  endtask

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_loop = 0; m_done = 0;
      m_idx = 0; m_rem = 0; m_last = 0; m_led = '0;
      for (int i = 0; i < 8; i++) begin
        m_tbl_led[i] = '0;
        m_tbl_dur[i] = 0;
      end
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run  = 1;
          m_last = int'(last_step);
          m_loop = loop;
          show(0);
        end
      end else if (stop) begin
        m_run = 0; m_idx = 0; m_led = '0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_idx < m_last) show(m_idx + 1);
          else if (m_loop) show(0);
          else begin
            m_run = 0; m_idx = 0; m_led = '0; m_done = 1;
          end
        end
      end
      if (cfg_we) begin
        m_tbl_led[cfg_addr] = cfg_led;
        m_tbl_dur[cfg_addr] = int'(cfg_dur);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      chk("cmp_led",  32'(led),  32'(m_led));
      chk("cmp_busy", 32'(busy), 32'(m_run));
      chk("cmp_done", 32'(done), 32'(m_done));
      chk("cmp_step", 32'(step), 32'(m_idx));
      if (done) n_done_seen++;
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input int a, input int l, input int d);
    cfg_we = 1; cfg_addr = 3'(a); cfg_led = 4'(l); cfg_dur = DUR_W'(d);
    cyc();
    cfg_we = 0;
  endtask

  task automatic start_run(input int last, input bit lp);
    last_step = 3'(last); loop = lp; start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    rst_n = 0; cfg_we = 0; cfg_addr = '0; cfg_led = '0; cfg_dur = '0;
    last_step = '0; loop = 0; start = 0; stop = 0;
    repeat (2) cyc();
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_step", 32'(step), 0);
    rst_n = 1;
    cmp_en = 1;
    cyc();

    // Single pass: 1 x8, 3 x4, F x12, then done.
    wr(0, 4'h1, 2); wr(1, 4'h3, 1); wr(2, 4'hF, 3);
    start_run(2, 0);
    chk("sp_start_led", 32'(led), 32'h1);
    chk("sp_start_busy", 32'(busy), 1);
    repeat (7) cyc();
    chk("sp_e0_end", 32'(led), 32'h1);
    cyc();
    chk("sp_e1_led", 32'(led), 32'h3);
    chk("sp_e1_step", 32'(step), 1);
    repeat (3) cyc();
    chk("sp_e1_end", 32'(led), 32'h3);
    cyc();
    chk("sp_e2_led", 32'(led), 32'hF);
    repeat (11) cyc();
    chk("sp_e2_end", 32'(led), 32'hF);
    chk("sp_e2_busy", 32'(busy), 1);
    cyc();
    chk("sp_done", 32'(done), 1);
    chk("sp_done_busy", 32'(busy), 0);
    chk("sp_done_led", 32'(led), 0);
    cyc();
    chk("sp_done_pulse", 32'(done), 0);

    // Loop with no gap at wrap, then stop without done.
    d0 = n_done_seen;
    start_run(2, 1);
    repeat (24) cyc();
    chk("lp_wrap_led", 32'(led), 32'h1);
    chk("lp_wrap_step", 32'(step), 0);
    chk("lp_wrap_busy", 32'(busy), 1);
    repeat (10) cyc();
    stop = 1;
    cyc();
    stop = 0;
    chk("lp_stop_led", 32'(led), 0);
    chk("lp_stop_busy", 32'(busy), 0);
    cyc();
    chk("lp_no_done", 32'(n_done_seen - d0), 0);

    // Collisions.
    last_step = 3'd2; loop = 0; start = 1; stop = 1;
    cyc();
    start = 0; stop = 0;
    chk("col_startstop_busy", 32'(busy), 0);
    start_run(2, 0);
    repeat (9) cyc();
    start = 1;
    cyc();
    start = 0;
    chk("col_restart_step", 32'(step), 1);
    chk("col_restart_led", 32'(led), 32'h3);
    stop = 1; cyc(); stop = 0;

    // Live rewrite, including write in the exact load cycle.
    start_run(1, 0);
    repeat (2) cyc();
    wr(1, 4'hA, 1);
    repeat (4) cyc();
    chk("lr_e0_led", 32'(led), 32'h1);
    cfg_we = 1; cfg_addr = 3'd1; cfg_led = 4'h5; cfg_dur = DUR_W'(1);
    cyc();
    cfg_we = 0;
    chk("lr_new_e1", 32'(led), 32'hA);
    repeat (3) cyc();
    chk("lr_e1_hold", 32'(led), 32'hA);
    cyc();
    chk("lr_done", 32'(done), 1);
    start_run(1, 0);
    repeat (8) cyc();
    chk("lr_rewritten_e1", 32'(led), 32'h5);
    repeat (4) cyc();

    // Zero duration behaves as one tick.
    wr(0, 4'h6, 0);
    start_run(0, 0);
    chk("zd_led", 32'(led), 32'h6);
    repeat (3) cyc();
    chk("zd_hold", 32'(led), 32'h6);
    cyc();
    chk("zd_done", 32'(done), 1);
    chk("zd_led_off", 32'(led), 0);

    // Reset in the middle of entry 1.
    start_run(1, 1);
    repeat (5) cyc();
    chk("mr_pre_step", 32'(step), 1);
    rst_n = 0;
    #1;
    chk("mr_led", 32'(led), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_step", 32'(step), 0);
    cyc();
    rst_n = 1;
    repeat (10) cyc();
    chk("mr_idle_busy", 32'(busy), 0);
    chk("mr_idle_led", 32'(led), 0);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
